aes_core_sched: RTL and testbench

Request scheduler that time-shares one `aes_cipher_top` encryption core between `NREQ` independent requesters. It performs round-robin arbitration and captures the winner's key/plaintext. It pulses the core's `ld`, waits for `done` under a watchdog, and returns the ciphertext with the requester's index over a valid/ready response port. It sits directly above the core in the cipher subsystem and is the only block that drives the core's load inputs.

---
 rtl/aes_core_sched_if.sv | 45 ++++
 rtl/aes_core_sched.sv | 188 ++++++++++++++++++
 tb/tb_aes_core_sched.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_core_sched_if.sv
// Request, core-load and response signals of the AES core scheduler.
// The master modport is the scheduler's view; slave is the surrounding system's.
interface aes_core_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*128-1:0] req_key;
    logic [NREQ*128-1:0] req_text;

    logic                core_ld;
    logic [127:0]        core_key;
    logic [127:0]        core_text_in;
    logic                core_done;
    logic [127:0]        core_text_out;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [127:0]        rsp_data;
    logic                rsp_err;

    logic                busy;

    modport master (
        input  req_valid, req_key, req_text,
        input  core_done, core_text_out,
        input  rsp_ready,
        output req_ready,
        output core_ld, core_key, core_text_in,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        output busy
    );

    modport slave (
        output req_valid, req_key, req_text,
        output core_done, core_text_out,
        output rsp_ready,
        input  req_ready,
        input  core_ld, core_key, core_text_in,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        input  busy
    );
endinterface

// File: rtl/aes_core_sched.sv
// Round-robin scheduler that time-shares one AES encryption core between NREQ
// requesters, guards each operation with a done watchdog and returns results over valid/ready.
module aes_core_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    aes_core_sched_if.master bus
);
    localparam int DW = 128;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic [IDW-1:0]  ptr_r;
    logic [IDW-1:0]  id_r;
    logic [IDW-1:0]  grant_s;
    logic [IDW-1:0]  ptr_nxt_s;
    logic [IDW:0]    sum_s;
    logic [IDW:0]    cand_s;
    logic            any_s;
    logic            accept_s;
    logic            timeout_s;

    logic [CW-1:0]   cnt_r;
    logic [DW-1:0]   key_r;
    logic [DW-1:0]   text_r;
    logic [DW-1:0]   rsp_data_r;
    logic            rsp_valid_r;
    logic            rsp_err_r;

    logic [NREQ-1:0] req_ready_s;
    logic            core_ld_s;
    logic            busy_s;

    // Rotating-priority search: first valid requester at or above ptr_r, wrapping.
    always_comb begin
        grant_s = '0;
        any_s   = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s  = {1'b0, ptr_r} + (IDW + 1)'(k);
            cand_s = (sum_s >= (IDW + 1)'(NREQ)) ? (sum_s - (IDW + 1)'(NREQ)) : sum_s;
            if (!any_s && bus.req_valid[cand_s[IDW-1:0]]) begin
                any_s   = 1'b1;
                grant_s = cand_s[IDW-1:0];
            end else begin
                any_s   = any_s;
                grant_s = grant_s;
            end
        end
    end

    assign ptr_nxt_s = (grant_s == IDW'(NREQ - 1)) ? '0 : (grant_s + IDW'(1));
    assign accept_s  = (state_r == IDLE) && any_s;
    assign timeout_s = (cnt_r == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a done in the last watchdog cycle still counts as success.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = accept_s ? LOAD : IDLE;
            LOAD:    state_nxt_s = BUSY;
            BUSY:    state_nxt_s = (bus.core_done || timeout_s) ? RESP : BUSY;
            RESP:    state_nxt_s = bus.rsp_ready ? IDLE : RESP;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State-decoded outputs: request grant, load strobe and busy flag.
    always_comb begin
        req_ready_s = '0;
        core_ld_s   = 1'b0;
        busy_s      = 1'b1;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (any_s) begin
                    req_ready_s = NREQ'(1) << grant_s;
                end else begin
                    req_ready_s = '0;
                end
            end
            LOAD: begin
                core_ld_s = 1'b1;
            end
            BUSY: begin
                busy_s = 1'b1;
            end
            RESP: begin
                busy_s = 1'b1;
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
    end

    // Winner capture; key and plaintext stay frozen until the next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_r  <= '0;
            text_r <= '0;
            id_r   <= '0;
            ptr_r  <= '0;
        end else if (accept_s) begin
            key_r  <= bus.req_key[int'(grant_s) * DW +: DW];
            text_r <= bus.req_text[int'(grant_s) * DW +: DW];
            id_r   <= grant_s;
            ptr_r  <= ptr_nxt_s;
        end
    end

    // Watchdog counter, cleared in the load cycle and running while the core works.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else begin
            case (state_r)
                LOAD:    cnt_r <= '0;
                BUSY:    cnt_r <= cnt_r + CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Response registers; core_done is only honoured while waiting on the core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= '0;
        end else begin
            case (state_r)
                BUSY: begin
                    if (bus.core_done) begin
                        rsp_data_r  <= bus.core_text_out;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                    end else if (timeout_s) begin
                        rsp_data_r  <= '0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= rsp_valid_r;
                end
            endcase
        end
    end

    assign bus.req_ready    = req_ready_s;
    assign bus.core_ld      = core_ld_s;
    assign bus.busy         = busy_s;
    assign bus.core_key     = key_r;
    assign bus.core_text_in = text_r;
    assign bus.rsp_valid    = rsp_valid_r;
    assign bus.rsp_id       = id_r;
    assign bus.rsp_data     = rsp_data_r;
    assign bus.rsp_err      = rsp_err_r;

endmodule

// File: tb/tb_aes_core_sched.sv
// Directed/randomized bench for aes_core_sched with a behavioural stub core and
// a round-robin reference model.
module tb_aes_core_sched;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 32;
    localparam int IDW     = 2;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] A5_BLK   = {16{8'hA5}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_core_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    aes_core_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           n_chk = 0;
    int           n_err = 0;
    int           ptr_m;
    logic [3:0]   valid_v;
    logic [127:0] keys  [NREQ];
    logic [127:0] texts [NREQ];
    int           rr_exp [6] = '{0, 1, 2, 3, 0, 1};

    int stub_lat;
    bit force_a5;
    bit extra_done;
    int cd;

    function automatic logic [127:0] ref_cipher(input logic [127:0] k, input logic [127:0] t);
        if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        return {k[63:0] ^ t[127:64], t[63:0] + k[127:64]};
    endfunction

    // Stub core: raises done stub_lat cycles after the load strobe (never if 0).
    always @(posedge clk or negedge rst) begin
        if (!rst) cd <= 0;
        else if (bus.core_ld) cd <= stub_lat;
        else if (cd > 0) cd <= cd - 1;
    end
    assign bus.core_done     = (cd == 1) || extra_done;
    assign bus.core_text_out = force_a5 ? A5_BLK : ref_cipher(bus.core_key, bus.core_text_in);

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int rr_pick(input int p, input logic [3:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int g);
        return (g < 0) ? 4'b0000 : (4'b0001 << g);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input logic [3:0] v);
        valid_v       = v;
        bus.req_valid = v;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_core_ld"},   bus.core_ld,      1'b0);
        chk({tag, "_core_key"},  bus.core_key,     128'h0);
        chk({tag, "_core_text"}, bus.core_text_in, 128'h0);
        chk({tag, "_rsp_data"},  bus.rsp_data,     128'h0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid,    1'b0);
        chk({tag, "_rsp_err"},   bus.rsp_err,      1'b0);
        chk({tag, "_rsp_id"},    bus.rsp_id,       2'd0);
        chk({tag, "_busy"},      bus.busy,         1'b0);
        chk({tag, "_req_ready"}, bus.req_ready,    4'b0000);
    endtask

    // One full operation: grant, load, wait for the response; returns in RESP at a negedge.
    task automatic serve(input int lat, input bit use_fips, output int g_obs, output int waited);
        int g_exp;
        int n;
        int extra;
        int exp_lat;
        logic [127:0] exp_data;
        stub_lat = lat;
        for (int i = 0; i < NREQ; i++) begin
            keys[i]  = rnd128();
            texts[i] = rnd128();
        end
        if (use_fips) begin
            keys[2]  = FIPS_KEY;
            texts[2] = FIPS_PT;
        end
        for (int i = 0; i < NREQ; i++) begin
            bus.req_key[i*128 +: 128]  = keys[i];
            bus.req_text[i*128 +: 128] = texts[i];
        end
        bus.req_valid = valid_v;
        #1;
        waited = 0;
        while (bus.req_ready == 4'b0000 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        g_exp = rr_pick(ptr_m, valid_v);
        chk("grant", bus.req_ready, onehot(g_exp));
        g_obs = -1;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g_obs = i;
        if (g_exp < 0) g_exp = 0;
        ptr_m = (g_exp + 1) % NREQ;
        @(posedge clk);
        @(negedge clk);
        chk("core_ld",        bus.core_ld,      1'b1);
        chk("core_key",       bus.core_key,     keys[g_exp]);
        chk("core_text",      bus.core_text_in, texts[g_exp]);
        chk("busy_in_op",     bus.busy,         1'b1);
        chk("ready_in_op",    bus.req_ready,    4'b0000);
        n = 0;
        extra = 0;
        while (!bus.rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.core_ld) extra++;
        end
        exp_lat  = (lat == 0) ? TIMEOUT + 1 : lat + 1;
        exp_data = (lat == 0) ? 128'h0 : (force_a5 ? A5_BLK : ref_cipher(keys[g_exp], texts[g_exp]));
        chk("rsp_latency",    n,             exp_lat);
        chk("extra_core_ld",  extra,         0);
        chk("rsp_valid",      bus.rsp_valid, 1'b1);
        chk("rsp_id",         bus.rsp_id,    g_exp);
        chk("rsp_data",       bus.rsp_data,  exp_data);
        chk("rsp_err",        bus.rsp_err,   (lat == 0) ? 1'b1 : 1'b0);
    endtask

    initial begin
        int g;
        int w;
        logic [127:0] snap_d;
        logic [3:0]   snap_c;

        rst = 1'b0;
        set_valid(4'b0000);
        bus.req_key   = '0;
        bus.req_text  = '0;
        bus.rsp_ready = 1'b0;
        stub_lat      = 0;
        force_a5      = 1'b0;
        extra_done    = 1'b0;
        ptr_m         = 0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;

        // Round robin with every requester valid.
        bus.rsp_ready = 1'b1;
        set_valid(4'b1111);
        for (int i = 0; i < 6; i++) begin
            serve(int'($urandom_range(1, 20)), 1'b0, g, w);
            chk("rr_order", g, rr_exp[i]);
        end

        // Only 1 and 3 valid with ptr at 2: 3 first.
        set_valid(4'b1010);
        serve(int'($urandom_range(1, 20)), 1'b0, g, w);
        chk("rr_skip_first", g, 3);
        serve(int'($urandom_range(1, 20)), 1'b0, g, w);
        chk("rr_skip_second", g, 1);

        // Single request carrying the FIPS-197 vector.
        set_valid(4'b0100);
        serve(10, 1'b1, g, w);
        chk("single_id", g, 2);
        chk("single_ct", bus.rsp_data, FIPS_CT);

        // Backpressure.
        set_valid(4'b1111);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        serve(int'($urandom_range(3, 12)), 1'b0, g, w);
        snap_d = bus.rsp_data;
        snap_c = {bus.rsp_valid, bus.rsp_id, bus.rsp_err};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_data",      bus.rsp_data, snap_d);
            chk("bp_ctrl",      {bus.rsp_valid, bus.rsp_id, bus.rsp_err}, snap_c);
            chk("bp_req_ready", bus.req_ready, 4'b0000);
            chk("bp_core_ld",   bus.core_ld, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_busy", bus.busy, 1'b0);
        serve(5, 1'b0, g, w);
        chk("bp_next_accept_wait", w, 0);

        // Watchdog, then a late done during RESP.
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        serve(0, 1'b0, g, w);
        snap_c = {bus.rsp_valid, bus.rsp_id, bus.rsp_err};
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        @(negedge clk);
        chk("late_done_data", bus.rsp_data, 128'h0);
        chk("late_done_ctrl", {bus.rsp_valid, bus.rsp_id, bus.rsp_err}, snap_c);
        bus.rsp_ready = 1'b1;
        @(negedge clk);

        // Done coinciding with the last watchdog cycle.
        force_a5 = 1'b1;
        serve(TIMEOUT, 1'b0, g, w);
        chk("collision_data", bus.rsp_data, A5_BLK);
        force_a5 = 1'b0;
        @(negedge clk);

        // Reset in the middle of an operation.
        stub_lat = 20;
        #1;
        w = 0;
        while (bus.req_ready == 4'b0000 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("midop_grant", bus.req_ready, onehot(rr_pick(ptr_m, valid_v)));
        @(posedge clk);
        repeat (5) @(negedge clk);
        chk("midop_busy", bus.busy, 1'b1);
        set_valid(4'b0000);
        rst = 1'b0;
        #1;
        check_reset("midop_reset");
        ptr_m = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midop_no_rsp", bus.rsp_valid, 1'b0);
        end
        rst = 1'b1;
        set_valid(4'b1111);
        serve(6, 1'b0, g, w);
        chk("post_reset_first", g, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
